// File: rtl/media_campioni_if.sv
`default_nettype none
// ============================================================================
// media_campioni_if : sample-in / mean-out dav_/rfd handshake bundle  (rev 1.0)
// ============================================================================
interface media_campioni_if #(
  parameter int W = 8
);
  logic         dav_in_;
  logic [W-1:0] data_in;
  logic         rfd_in;
  logic         dav_out_;
  logic         rfd_out;
  logic [W-1:0] media;

  // master is the surrounding pipeline, slave is the averaging block
  modport master (
    output dav_in_, data_in, rfd_out,
    input  rfd_in, dav_out_, media
  );
  modport slave (
    input  dav_in_, data_in, rfd_out,
    output rfd_in, dav_out_, media
  );
endinterface
`default_nettype wire

// File: rtl/media_campioni.sv
`default_nettype none
// ============================================================================
// media_campioni : floor mean of 2**NLOG2 handshaked samples       (rev 1.0)
// ============================================================================
module media_campioni #(
  parameter int W     = 8,
  parameter int NLOG2 = 2
) (
  input  wire              clock,
  input  wire              reset,
  media_campioni_if.slave  bus
);

  typedef enum logic [1:0] {
    R0 = 2'd0,
    R1 = 2'd1,
    W0 = 2'd2,
    W1 = 2'd3
  } state_t;

  localparam logic [NLOG2-1:0] c_cnt_one = NLOG2'(1);

  state_t               r_state;
  logic                 r_rfd_in;
  logic                 r_dav_out_;
  logic [W-1:0]         r_media;
  logic [W+NLOG2-1:0]   r_sum;
  logic [NLOG2-1:0]     r_cnt;

  assign bus.rfd_in   = r_rfd_in;
  assign bus.dav_out_ = r_dav_out_;
  assign bus.media    = r_media;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= R0;
      r_rfd_in   <= 1'b1;
      r_dav_out_ <= 1'b1;
      r_media    <= '0;
      r_sum      <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        R0: begin
          if (!bus.dav_in_) begin
            r_sum    <= r_sum + {{NLOG2{1'b0}}, bus.data_in};
            r_cnt    <= r_cnt + c_cnt_one;
            r_rfd_in <= 1'b0;
            r_state  <= R1;
          end
        end
        R1: begin
          // wait for the producer to drop dav_in_ so one low phase = one sample
          if (bus.dav_in_) begin
            if (r_cnt == '0) begin
              r_media    <= r_sum[W+NLOG2-1:NLOG2];
              r_dav_out_ <= 1'b0;
              r_state    <= W0;
            end else begin
              r_rfd_in <= 1'b1;
              r_state  <= R0;
            end
          end
        end
        W0: begin
          if (!bus.rfd_out) begin
            r_dav_out_ <= 1'b1;
            r_sum      <= '0;
            r_state    <= W1;
          end
        end
        W1: begin
          if (bus.rfd_out) begin
            r_rfd_in <= 1'b1;
            r_state  <= R0;
          end
        end
        default: r_state <= R0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_media_campioni.sv
`default_nettype none
// ============================================================================
// tb_media_campioni : table-driven + scoreboard bench for media_campioni (rev 1.0)
// ============================================================================
module tb_media_campioni;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  media_campioni_if #(.W(8)) bus  ();
  media_campioni_if #(.W(8)) bus3 ();

  media_campioni #(.W(8), .NLOG2(2)) dut  (.clock(clock), .reset(reset), .bus(bus));
  media_campioni #(.W(8), .NLOG2(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3));

  typedef struct packed {
    logic [3:0][7:0] s;
    logic [7:0]      m;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] sb [$];
  int         checks = 0;
  int         errors = 0;

  function automatic vec_t mk(input logic [7:0] a, b, c, d, m);
    vec_t v;
    v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d; v.m = m;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic rfd(input bit b3);
    return b3 ? bus3.rfd_in : bus.rfd_in;
  endfunction
  function automatic logic davo(input bit b3);
    return b3 ? bus3.dav_out_ : bus.dav_out_;
  endfunction
  function automatic logic [7:0] med(input bit b3);
    return b3 ? bus3.media : bus.media;
  endfunction

  task automatic drive(input bit b3, input logic dav, input logic [7:0] d);
    if (b3) begin bus3.dav_in_ = dav; bus3.data_in = d; end
    else    begin bus.dav_in_  = dav; bus.data_in  = d; end
  endtask

  task automatic set_rfd_out(input bit b3, input logic v);
    if (b3) bus3.rfd_out = v; else bus.rfd_out = v;
  endtask

  task automatic wait_rfd_high(input bit b3);
    int n = 0;
    while (rfd(b3) !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    chk("wait_rfd_in_high", 32'(rfd(b3)), 1);
  endtask

  task automatic check_reset_values();
    chk("reset_rfd_in",   32'(bus.rfd_in),    1);
    chk("reset_dav_out_", 32'(bus.dav_out_),  1);
    chk("reset_media",    32'(bus.media),     0);
    chk("reset3_rfd_in",  32'(bus3.rfd_in),   1);
    chk("reset3_dav_out_",32'(bus3.dav_out_), 1);
    chk("reset3_media",   32'(bus3.media),    0);
  endtask

  // Wait for dav_out_ to fall, then pop the scoreboard and compare media.
  task automatic collect(input bit b3);
    int n = 0;
    while (davo(b3) !== 1'b0 && n < 5) begin @(negedge clock); n++; end
    chk("wait_dav_out_low", 32'(davo(b3)), 0);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty actual=%0d required=expected_entry", med(b3));
    end else begin
      chk("media", 32'(med(b3)), 32'(sb.pop_front()));
    end
    chk("rfd_in_low_while_pending", 32'(rfd(b3)), 0);
  endtask

  task automatic send_sample(input bit b3, input logic [7:0] v, input bit last,
                             input logic [7:0] exp_m);
    wait_rfd_high(b3);
    if (last) sb.push_back(exp_m);
    drive(b3, 1'b0, v);
    @(negedge clock);
    chk("rfd_in_low_after_accept", 32'(rfd(b3)), 0);
    drive(b3, 1'b1, v);
    @(negedge clock);
    if (!last) begin
      chk("rfd_in_back_high", 32'(rfd(b3)), 1);
      chk("dav_out_idle",     32'(davo(b3)), 1);
    end else begin
      collect(b3);
    end
  endtask

  task automatic drain(input bit b3);
    set_rfd_out(b3, 1'b0);
    @(negedge clock);
    chk("dav_out_released", 32'(davo(b3)), 1);
    chk("rfd_in_low_in_w1", 32'(rfd(b3)),  0);
    set_rfd_out(b3, 1'b1);
    @(negedge clock);
    chk("rfd_in_after_w1",  32'(rfd(b3)),  1);
    chk("dav_out_after_w1", 32'(davo(b3)), 1);
  endtask

  task automatic send_block(input logic [7:0] a, b, c, d, m);
    send_sample(1'b0, a, 1'b0, m);
    send_sample(1'b0, b, 1'b0, m);
    send_sample(1'b0, c, 1'b0, m);
    send_sample(1'b0, d, 1'b1, m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(8'd10,  8'd20,  8'd30,  8'd41,  8'd25);
    vecs[1] = mk(8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    vecs[2] = mk(8'd0,   8'd0,   8'd0,   8'd0,   8'd0);
    vecs[3] = mk(8'd1,   8'd2,   8'd3,   8'd4,   8'd2);
    vecs[4] = mk(8'd7,   8'd0,   8'd0,   8'd0,   8'd1);
    vecs[5] = mk(8'd200, 8'd100, 8'd50,  8'd3,   8'd88);

    bus.dav_in_  = 1'b1; bus.data_in  = '0; bus.rfd_out  = 1'b1;
    bus3.dav_in_ = 1'b1; bus3.data_in = '0; bus3.rfd_out = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_reset_values();

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++)
        send_sample(1'b0, vecs[v].s[i], i == 3, vecs[v].m);
      drain(1'b0);
    end

    // slow downstream with an eager producer parked on dav_in_=0
    send_block(8'd40, 8'd40, 8'd40, 8'd44, 8'd41);
    drive(1'b0, 1'b0, 8'd200);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      chk("stall_dav_out_", 32'(bus.dav_out_), 0);
      chk("stall_media",    32'(bus.media),    41);
      chk("stall_rfd_in",   32'(bus.rfd_in),   0);
    end
    drive(1'b0, 1'b1, 8'd200);
    drain(1'b0);
    send_block(8'd8, 8'd8, 8'd8, 8'd8, 8'd8);
    drain(1'b0);

    // dav_in_ held low across many edges while data_in wanders
    wait_rfd_high(1'b0);
    drive(1'b0, 1'b0, 8'd5);
    @(negedge clock);
    chk("held_accept_rfd_in", 32'(bus.rfd_in), 0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 8'(250 - k));
      @(negedge clock);
      chk("held_rfd_in",   32'(bus.rfd_in),   0);
      chk("held_dav_out_", 32'(bus.dav_out_), 1);
    end
    drive(1'b0, 1'b1, 8'd0);
    @(negedge clock);
    chk("held_release_rfd_in", 32'(bus.rfd_in), 1);
    send_sample(1'b0, 8'd5, 1'b0, 8'd5);
    send_sample(1'b0, 8'd5, 1'b0, 8'd5);
    send_sample(1'b0, 8'd5, 1'b1, 8'd5);
    drain(1'b0);

    // reset part-way through a block discards the partial sum
    send_sample(1'b0, 8'd100, 1'b0, 8'd0);
    send_sample(1'b0, 8'd100, 1'b0, 8'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_values();
    send_block(8'd1, 8'd2, 8'd3, 8'd4, 8'd2);
    drain(1'b0);

    // eight-sample instance: result only after the 8th handshake
    for (int i = 1; i <= 8; i++)
      send_sample(1'b1, 8'(i), i == 8, 8'd4);
    drain(1'b1);

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
